// File: rtl/serdes_pkg.sv
// Shared types and Hamming helpers for the serdes link: parity sizing,
// frame length and the encode/decode functions used by both ends of the line.
package serdes_pkg;

    localparam int MAX_W   = 32;
    localparam int MAX_P   = 6;
    localparam int MAX_N   = MAX_W + MAX_P;

    typedef logic [MAX_W-1:0] word_t;
    typedef logic [MAX_N-1:0] code_t;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
    typedef enum logic {DES_IDLE, DES_RECV} des_state_t;

    function automatic int parity_count(input int dw);
        int p;
        p = 0;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic int n_bits(input int dw, input int ecc);
        return (ecc != 0) ? dw + parity_count(dw) : dw;
    endfunction

    // Codeword bit (pos-1) holds Hamming position pos; parity sits at powers of two.
    function automatic code_t hamming_encode(input word_t d, input int n);
        code_t cw;
        int j;
        logic par;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos <= MAX_N; pos++) begin
            if (pos <= n && (pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < MAX_P; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= MAX_N; pos++) begin
                if (pos <= n && (pos & (1 << i)) != 0) par ^= cw[pos-1];
            end
            if ((1 << i) <= n) cw[(1 << i) - 1] = par;
        end
        return cw;
    endfunction

    function automatic word_t hamming_decode(input code_t cw_in, input int n);
        code_t cw;
        word_t d;
        int syn;
        int j;
        cw  = cw_in;
        syn = 0;
        for (int pos = 1; pos <= MAX_N; pos++) begin
            if (pos <= n && cw[pos-1]) syn ^= pos;
        end
        if (syn != 0 && syn <= n) cw[syn-1] = ~cw[syn-1];
        d = '0;
        j = 0;
        for (int pos = 1; pos <= MAX_N; pos++) begin
            if (pos <= n && (pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic code_t frame_encode(input word_t d, input int n, input int ecc);
        return (ecc != 0) ? hamming_encode(d, n) : code_t'(d);
    endfunction

    function automatic word_t frame_decode(input code_t cw, input int n, input int ecc);
        return (ecc != 0) ? hamming_decode(cw, n) : cw[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/serdes_fifo.sv
// Synchronous show-ahead FIFO with a registered occupancy count driving full/empty.
module serdes_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/serdes.sv
// Loopback serdes: FIFO-buffered words are framed (start bit + optional Hamming
// codeword) onto an internal serial line and recovered by a receiver FSM.
module serdes
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HAS_ECC    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] parallel_in_i,
    input  logic                  valid_in_i,
    output logic                  ready_out_o,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_out_o,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o
);

    localparam int N_BITS = n_bits(DATA_WIDTH, HAS_ECC);
    localparam int CNT_W  = $clog2(N_BITS + 1);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    ser_state_t            ser_state;
    logic [N_BITS-1:0]     ser_sreg;
    logic [CNT_W-1:0]      ser_cnt;
    logic                  ser_q;
    logic                  ser_line;

    des_state_t            des_state;
    logic [N_BITS-1:0]     des_sreg;
    logic [CNT_W-1:0]      des_cnt;
    logic                  frame_vld_p0;

    assign ready_out_o = !fifo_full_o && !rst_n_i;
    assign push        = valid_in_i && ready_out_o;
    assign pop         = (ser_state == SER_IDLE) && !fifo_empty_o;
    assign ser_line    = ser_q;

    serdes_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_n_i),
        .wr_en   (push),
        .wr_data (parallel_in_i),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full_o),
        .empty   (fifo_empty_o)
    );

    // Transmit: start bit, then codeword LSB (position 1) first.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            ser_state <= SER_IDLE;
            ser_cnt   <= '0;
            ser_q     <= 1'b0;
        end else begin
            case (ser_state)
                SER_IDLE: begin
                    if (!fifo_empty_o) begin
                        ser_sreg  <= N_BITS'(frame_encode(word_t'(fifo_rdata), N_BITS, HAS_ECC));
                        ser_q     <= 1'b1;
                        ser_cnt   <= '0;
                        ser_state <= SER_SHIFT;
                    end else begin
                        ser_q <= 1'b0;
                    end
                end
                SER_SHIFT: begin
                    ser_q    <= ser_sreg[0];
                    ser_sreg <= ser_sreg >> 1;
                    ser_cnt  <= ser_cnt + 1'b1;
                    if (ser_cnt == CNT_W'(N_BITS - 1)) ser_state <= SER_IDLE;
                end
                default: ser_state <= SER_IDLE;
            endcase
        end
    end

    // Receive: stage p0 flags a complete frame, the output stage decodes it.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            des_state      <= DES_IDLE;
            des_cnt        <= '0;
            frame_vld_p0   <= 1'b0;
            valid_out_o    <= 1'b0;
            parallel_out_o <= '0;
        end else begin
            frame_vld_p0 <= 1'b0;
            valid_out_o  <= frame_vld_p0;
            if (frame_vld_p0)
                parallel_out_o <= DATA_WIDTH'(frame_decode(code_t'(des_sreg), N_BITS, HAS_ECC));
            case (des_state)
                DES_IDLE: begin
                    if (ser_line) begin
                        des_cnt   <= '0;
                        des_state <= DES_RECV;
                    end
                end
                DES_RECV: begin
                    des_sreg <= (des_sreg >> 1) | (N_BITS'(ser_line) << (N_BITS - 1));
                    des_cnt  <= des_cnt + 1'b1;
                    if (des_cnt == CNT_W'(N_BITS - 1)) begin
                        des_state    <= DES_IDLE;
                        frame_vld_p0 <= 1'b1;
                    end
                end
                default: des_state <= DES_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serdes.sv
// Directed bench for serdes: one raw (8-bit, no ECC) and one Hamming instance on a shared clock/reset.
module tb_serdes;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin0, pin1;
    logic       vin0, vin1;
    logic       rdy0, rdy1;
    logic [7:0] pout0, pout1;
    logic       vout0, vout1;
    logic       full0, full1;
    logic       empty0, empty1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serdes #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .HAS_ECC(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst), .parallel_in_i(pin0), .valid_in_i(vin0),
        .ready_out_o(rdy0), .parallel_out_o(pout0), .valid_out_o(vout0),
        .fifo_full_o(full0), .fifo_empty_o(empty0)
    );

    serdes #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .HAS_ECC(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst), .parallel_in_i(pin1), .valid_in_i(vin1),
        .ready_out_o(rdy1), .parallel_out_o(pout1), .valid_out_o(vout1),
        .fifo_full_o(full1), .fifo_empty_o(empty1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vin0 = 1'b0; vin1 = 1'b0; pin0 = '0; pin1 = '0;
        repeat (3) tick();
        checks++;
        if (empty0 !== 1'b1 || full0 !== 1'b0 || rdy0 !== 1'b0 || vout0 !== 1'b0 ||
            pout0 !== 8'h00 || dut0.ser_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_raw empty=%b full=%b rdy=%b vld=%b out=%h line=%b required 1 0 0 0 00 0",
                     empty0, full0, rdy0, vout0, pout0, dut0.ser_q);
        end
        checks++;
        if (empty1 !== 1'b1 || full1 !== 1'b0 || rdy1 !== 1'b0 || vout1 !== 1'b0 ||
            pout1 !== 8'h00 || dut1.ser_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_ecc empty=%b full=%b rdy=%b vld=%b out=%h line=%b required 1 0 0 0 00 0",
                     empty1, full1, rdy1, vout1, pout1, dut1.ser_q);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || empty0 !== 1'b1 || rdy1 !== 1'b1 || empty1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release rdy=%b/%b empty=%b/%b required 1/1 1/1", rdy0, rdy1, empty0, empty1);
        end
        tick();
    endtask

    task automatic test_raw_latency;
        int lat = -1;
        int pulses = 0;
        logic [7:0] got = '0;
        pin0 = 8'hA5; vin0 = 1'b1;
        tick();
        vin0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (vout0) begin
                pulses++;
                if (lat < 0) begin lat = k; got = pout0; end
            end
        end
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL raw_latency got %0d required 11", lat); end
        checks++;
        if (got !== 8'hA5) begin errors++; $display("FAIL raw_data got %h required a5", got); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL raw_pulses got %0d required 1", pulses); end
        checks++;
        if (pout0 !== 8'hA5) begin errors++; $display("FAIL raw_hold got %h required a5", pout0); end
    endtask

    task automatic test_ecc;
        for (int pass = 0; pass < 2; pass++) begin
            int lat = -1;
            int pulses = 0;
            logic [7:0]  got = '0;
            logic [11:0] cap = '0;
            pin1 = 8'h3C; vin1 = 1'b1;
            tick();
            vin1 = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (k >= 2 && k <= 13) cap[k-2] = dut1.ser_line;
                if (pass == 1 && k == 6) force dut1.ser_line = 1'b1;
                if (pass == 1 && k == 7) release dut1.ser_line;
                if (vout1) begin
                    pulses++;
                    if (lat < 0) begin lat = k; got = pout1; end
                end
            end
            if (pass == 0) begin
                checks++;
                if (cap !== 12'h362) begin errors++; $display("FAIL ecc_codeword got %h required 362", cap); end
            end else begin
                checks++;
                if (cap[4] !== 1'b0) begin errors++; $display("FAIL ecc_bit5_clean got %b required 0", cap[4]); end
            end
            checks++;
            if (lat !== 15) begin errors++; $display("FAIL ecc_latency pass %0d got %0d required 15", pass, lat); end
            checks++;
            if (got !== 8'h3C) begin errors++; $display("FAIL ecc_data pass %0d got %h required 3c", pass, got); end
            checks++;
            if (pulses !== 1) begin errors++; $display("FAIL ecc_pulses pass %0d got %0d required 1", pass, pulses); end
        end
    endtask

    task automatic test_fill;
        int q[$];
        int n_acc = 0;
        int n_out = 0;
        int extra = 0;
        int expv;
        bit saw_full = 0;
        bit saw_low  = 0;
        bit rdy_bad  = 0;
        for (int c = 0; c < 700 && (c < 40 || q.size() > 0); c++) begin
            if (c < 40) begin vin1 = 1'b1; pin1 = c[7:0]; end
            else vin1 = 1'b0;
            if (full1) saw_full = 1;
            if (!rdy1) saw_low = 1;
            if (rdy1 !== !full1) rdy_bad = 1;
            if (vin1 && rdy1) begin q.push_back(c); n_acc++; end
            tick();
            if (vout1) begin
                n_out++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL fill_extra_word got %h required none", pout1);
                end else begin
                    expv = q.pop_front();
                    if (pout1 !== expv[7:0]) begin
                        errors++;
                        $display("FAIL fill_order got %h required %h", pout1, expv[7:0]);
                    end
                end
            end
        end
        vin1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (vout1) extra++;
        end
        checks++;
        if (saw_full !== 1'b1) begin errors++; $display("FAIL fill_full_seen got 0 required 1"); end
        checks++;
        if (saw_low !== 1'b1 || rdy_bad !== 1'b0) begin
            errors++; $display("FAIL fill_ready low_seen=%b mismatch=%b required 1 0", saw_low, rdy_bad);
        end
        checks++;
        if (q.size() !== 0 || n_out !== n_acc || n_acc <= 16) begin
            errors++; $display("FAIL fill_count accepted=%0d out=%0d left=%0d required out=accepted>16 left=0",
                               n_acc, n_out, q.size());
        end
        checks++;
        if (extra !== 0 || empty1 !== 1'b1) begin
            errors++; $display("FAIL fill_drain extra=%0d empty=%b required 0 1", extra, empty1);
        end
    endtask

    task automatic test_back_to_back;
        int times[$];
        logic [7:0] vals[$];
        for (int k = 0; k < 60; k++) begin
            if (k < 3) begin vin0 = 1'b1; pin0 = 8'(k + 1); end
            else vin0 = 1'b0;
            tick();
            if (vout0) begin times.push_back(k); vals.push_back(pout0); end
        end
        checks++;
        if (times.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d required 3", times.size()); end
        for (int i = 0; i < times.size() && i < 3; i++) begin
            checks++;
            if (times[i] !== 11 + 9 * i || vals[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL b2b_word%0d edge=%0d data=%h required edge=%0d data=%h",
                         i, times[i], vals[i], 11 + 9 * i, 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        for (int k = 0; k < 50; k++) begin
            if (k < 3) begin vin0 = 1'b1; pin0 = 8'h55 + 8'(k * 17); end
            else vin0 = 1'b0;
            if (k == 6) rst = 1'b1;
            if (k == 8) rst = 1'b0;
            tick();
            if (vout0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses got %0d required 0", pulses); end
        checks++;
        if (empty0 !== 1'b1 || dut0.ser_q !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL midreset_state empty=%b line=%b rdy=%b required 1 0 1", empty0, dut0.ser_q, rdy0);
        end
    endtask

    initial begin
        rst = 1'b1;
        vin0 = 1'b0; vin1 = 1'b0; pin0 = '0; pin1 = '0;
        test_reset();
        test_raw_latency();
        test_ecc();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
